conv3x3_window_ctrl: RTL

- Raster-scan sequencer feeding conv3x3_single_ch.
- Accepts one pixel per cycle via a valid/ready handshake and buffers two image rows in line buffers.
- Assembles the 3x3 window on p00..p22 and pulses win_valid only for fully-interior windows (valid convolution, no padding).
- Runs one frame per start pulse and signals frame completion.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv3x3_line_buf.sv | 26 ++
 rtl/conv3x3_window_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 window controller.
// CONV_STRIDE2_EN selects stride-2 window emission (also changes win_count).
package conv_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Number of win_valid pulses in one w x h frame.
    function automatic int win_count(input int w, input int h);
`ifdef CONV_STRIDE2_EN
        return ((w - 1) / 2) * ((h - 1) / 2);
`else
        return (w - 2) * (h - 2);
`endif
    endfunction

    localparam int WIN_COUNT_DEFAULT = win_count(8, 8);

endpackage

// File: rtl/conv3x3_line_buf.sv
// One image row of pixels: synchronous write, asynchronous read at the same column.
// Contents are intentionally not reset.
module conv3x3_line_buf #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [COL_W-1:0]         col_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
    output logic signed [DATA_W-1:0] rd_data_o
);

    logic signed [DATA_W-1:0] mem_q [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[col_i] <= wr_data_i;
        end
    end

    // Read returns the pre-write value, giving read-before-write on accept.
    assign rd_data_o = mem_q[col_i];

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Raster-scan 3x3 window sequencer with two line buffers; one frame per start.
// Define CONV_STRIDE2_EN to emit only windows at even (row-2, col-2).
module conv3x3_window_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic signed [DATA_W-1:0] p00,
    output logic signed [DATA_W-1:0] p01,
    output logic signed [DATA_W-1:0] p02,
    output logic signed [DATA_W-1:0] p10,
    output logic signed [DATA_W-1:0] p11,
    output logic signed [DATA_W-1:0] p12,
    output logic signed [DATA_W-1:0] p20,
    output logic signed [DATA_W-1:0] p21,
    output logic signed [DATA_W-1:0] p22,
    output logic                     win_valid,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_e                   state_q;
    logic [ROW_W-1:0]         row_q;
    logic [COL_W-1:0]         col_q;
    logic                     win_valid_q;
    logic                     accept;
    logic                     last_pix;
    logic                     win_hit;
    logic signed [DATA_W-1:0] lb1_rd;
    logic signed [DATA_W-1:0] lb2_rd;
    logic signed [DATA_W-1:0] row_in [3];
    logic [2:0][2:0][DATA_W-1:0] win_taps;

    assign pix_ready  = (state_q == STREAM);
    assign busy       = (state_q == STREAM);
    assign frame_done = (state_q == DONE);
    assign win_valid  = win_valid_q;

    assign accept   = pix_valid & pix_ready;
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Requiring col>=2 keeps taps that straddle a row wrap from ever being flagged.
`ifdef CONV_STRIDE2_EN
    assign win_hit = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2))
                     && !row_q[0] && !col_q[0];
`else
    assign win_hit = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= win_hit;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STREAM;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                        if (last_pix) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // lb1 holds the previous row, lb2 the one before it.
    conv3x3_line_buf #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb1 (
        .clk       (clk),
        .wr_en_i   (accept),
        .col_i     (col_q),
        .wr_data_i (pix_in),
        .rd_data_o (lb1_rd)
    );

    conv3x3_line_buf #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb2 (
        .clk       (clk),
        .wr_en_i   (accept),
        .col_i     (col_q),
        .wr_data_i (lb1_rd),
        .rd_data_o (lb2_rd)
    );

    assign row_in[0] = lb2_rd;
    assign row_in[1] = lb1_rd;
    assign row_in[2] = pix_in;

    for (genvar gi = 0; gi < 3; gi++) begin : g_tap_row
        logic signed [DATA_W-1:0] tap_q [3];

        always_ff @(posedge clk) begin
            if (rst) begin
                tap_q <= '{default: '0};
            end else if (accept) begin
                tap_q[0] <= tap_q[1];
                tap_q[1] <= tap_q[2];
                tap_q[2] <= row_in[gi];
            end
        end

        assign win_taps[gi] = {tap_q[2], tap_q[1], tap_q[0]};
    end

    assign p00 = win_taps[0][0];
    assign p01 = win_taps[0][1];
    assign p02 = win_taps[0][2];
    assign p10 = win_taps[1][0];
    assign p11 = win_taps[1][1];
    assign p12 = win_taps[1][2];
    assign p20 = win_taps[2][0];
    assign p21 = win_taps[2][1];
    assign p22 = win_taps[2][2];

endmodule
